i2s_sample_transmitter: RTL and testbench

Consumer side of the sample interface that music_player produces. Accepts 16-bit samples via sample/sample_ready and serialises each one as standard I2S to an external DAC, duplicating the mono sample into both the left and right slots. Emits a one-clk new_frame pulse once per audio frame. This pulse drives music_player's NewFrame input and paces the whole player.

---
 rtl/i2s_sample_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_i2s_sample_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_transmitter.sv
// i2s_sample_transmitter
// Serialises 16-bit mono samples as standard I2S (Philips, one-bit delay)
// and sends the same sample in both the left and right slots. Emits a
// one-clk new_frame strobe per audio frame, which paces the upstream
// player.
// Optional feature (macro I2S_UNDERRUN_CNT_EN): adds an 8-bit saturating
// underrun_count output.
//
// Sample handshake: sample_ready is a one-clk valid strobe with no ready
// back-pressure. The block always accepts the sample presented with it.
// new_frame is the request for the next sample. It is high during the clk
// whose closing edge loads the frame, so a sample strobed in that same clk
// goes straight into the frame without passing through the holding register.
module i2s_sample_transmitter #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] sample,
  input  logic                   sample_ready,
  output logic                   new_frame,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   underrun
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [7:0]             underrun_count
`endif
);

  localparam int                 DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int                 MSB       = SAMPLE_BITS - 1;
  // bit_cnt values just before the falling events that load each slot
  localparam logic [4:0]         LEFT_PRE  = 5'd0;
  localparam logic [4:0]         RIGHT_PRE = 5'(SAMPLE_BITS);

  // bit clock generation
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic                   div_wrap;
  logic                   fall_evt;

  // frame position
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   lrclk_q, lrclk_d;
  logic                   frame_start;
  logic                   right_load;

  // sample storage and serialiser
  logic [SAMPLE_BITS-1:0] hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [SAMPLE_BITS-1:0] cur_q, cur_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] load_word;

  // Event decode: bclk toggles when the divider wraps. A toggle that starts
  // from bclk=1 is a falling event, and all frame state moves on those.
  always_comb begin
    div_wrap    = (div_q == DIV_LAST);
    fall_evt    = div_wrap && bclk_q;
    frame_start = fall_evt && (bit_cnt_q == LEFT_PRE);
    right_load  = fall_evt && (bit_cnt_q == RIGHT_PRE);
  end

  // Divider and bclk next state
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    bclk_d = bclk_q;
    if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end
  end

  // Bit counter and word select advance together on each falling event
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      lrclk_d   = bit_cnt_d[4];
    end
  end

  // Choose the frame word: a same-clk strobe wins over the holding register,
  // and with neither present the previous word is repeated.
  always_comb begin
    if (sample_ready) begin
      load_word = sample;
    end else if (hold_valid_q) begin
      load_word = hold_q;
    end else begin
      load_word = cur_q;
    end
  end

  // Holding register: last strobe before the frame start wins. The frame
  // start always empties it, including when a bypass sample arrives then.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (frame_start) begin
      hold_valid_d = 1'b0;
    end else if (sample_ready) begin
      hold_d       = sample;
      hold_valid_d = 1'b1;
    end
  end

  // Serialiser: load at each slot start and shift on the other falling
  // events. The shift MSB drives sdata directly, so the MSB appears one
  // bclk after the lrclk transition, which gives the I2S one-bit delay.
  always_comb begin
    cur_d   = cur_q;
    shift_d = shift_q;
    if (frame_start) begin
      cur_d   = load_word;
      shift_d = load_word;
    end else if (right_load) begin
      shift_d = cur_q;
    end else if (fall_evt) begin
      shift_d = {shift_q[MSB-1:0], 1'b0};
    end
  end

  // State registers, all cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= 5'd0;
      lrclk_q      <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cur_q        <= '0;
      shift_q      <= '0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cur_q        <= cur_d;
      shift_q      <= shift_d;
    end
  end

  // Frame strobes come from registered state. A reset therefore drops them
  // at once, and they last exactly one clk.
  always_comb begin
    new_frame = frame_start;
    underrun  = frame_start && !hold_valid_q && !sample_ready;
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
  assign sdata = shift_q[MSB];

`ifdef I2S_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  // Saturating count of underrun pulses
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  // Underrun counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ucnt_q <= 8'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Testbench for i2s_sample_transmitter (CLK_DIV=2).
// The reference model derives every output from the number of clk edges
// since reset release. bclk, bit position, slot and frame starts come from
// integer arithmetic. The word to send is chosen from the sample strobes by
// the last-wins and bypass rules. Whole slots are also collected on bclk
// rising and compared against a queue of expected frame words.
module tb_i2s_sample_transmitter;

  localparam int D     = 2;
  localparam int FRAME = 64 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample = 16'h0;
  logic        sample_ready = 1'b0;
  logic        new_frame, bclk, lrclk, sdata, underrun;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [7:0]  underrun_count;
`endif

  i2s_sample_transmitter #(.CLK_DIV(D), .SAMPLE_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_ready (sample_ready),
    .new_frame    (new_frame),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n = 0;          // clk edges since reset release
  bit          pend_v = 1'b0;  // model: sample waiting for the next frame
  logic [15:0] pend = 16'h0;
  logic [15:0] tx_word = 16'h0; // model: word of the current frame
  int          ur_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] left_acc = 16'h0;
  logic [15:0] right_acc = 16'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  function automatic bit fs_at(input int m);
    return ((m % (2 * D)) == 0) && (((m / (2 * D)) % 32) == 1);
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_bclk"}, {31'd0, bclk}, 32'd0);
    check_eq({tag, "_lrclk"}, {31'd0, lrclk}, 32'd0);
    check_eq({tag, "_sdata"}, {31'd0, sdata}, 32'd0);
    check_eq({tag, "_new_frame"}, {31'd0, new_frame}, 32'd0);
    check_eq({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
`ifdef I2S_UNDERRUN_CNT_EN
    check_eq({tag, "_ucnt"}, {24'd0, underrun_count}, 32'd0);
`endif
  endtask

  // Assert reset between clock edges and check that outputs clear at once.
  // Then release reset just after a rising edge so that n=0 means no edges yet.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    sample_ready = 1'b0;
    sample = 16'h0;
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs(tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs({tag, "_hold"});
    @(posedge clk);
    #2;
    reset = 1'b1;
    n = 0;
    pend_v = 1'b0;
    pend = 16'h0;
    tx_word = 16'h0;
    ur_cnt = 0;
    exp_q.delete();
    left_acc = 16'h0;
    right_acc = 16'h0;
  endtask

  // One clk cycle: drive the inputs, check the outputs against the model,
  // then advance the model across the coming rising edge.
  task automatic step(input logic sr, input logic [15:0] val);
    int   k, b, idx;
    logic exp_bclk, exp_lr, exp_sd, exp_ur;
    bit   fs_next;
    @(negedge clk);
    sample_ready = sr;
    sample = val;
    #1;
    k        = n / (2 * D);
    b        = k % 32;
    exp_bclk = ((n / D) % 2) == 1;
    exp_lr   = (b >= 16);
    idx      = (16 - (b % 16)) % 16;
    exp_sd   = (k == 0) ? 1'b0 : tx_word[idx];
    fs_next  = fs_at(n + 1);
    exp_ur   = fs_next && !pend_v && !sr;
    check_eq("bclk", {31'd0, bclk}, {31'd0, exp_bclk});
    check_eq("lrclk", {31'd0, lrclk}, {31'd0, exp_lr});
    check_eq("sdata", {31'd0, sdata}, {31'd0, exp_sd});
    check_eq("new_frame", {31'd0, new_frame}, {31'd0, fs_next});
    check_eq("underrun", {31'd0, underrun}, {31'd0, exp_ur});
`ifdef I2S_UNDERRUN_CNT_EN
    check_eq("ucnt", {24'd0, underrun_count}, ur_cnt);
`endif
    // Collect whole slots as a DAC would see them on bclk rising.
    if (k > 0 && (n % (2 * D)) == D) begin
      if (b >= 1 && b <= 16) begin
        left_acc = {left_acc[14:0], sdata};
        if (b == 16 && exp_q.size() > 0) check_eq("left_slot", {16'd0, left_acc}, {16'd0, exp_q[0]});
      end else begin
        right_acc = {right_acc[14:0], sdata};
        if (b == 0 && exp_q.size() > 0) begin
          check_eq("right_slot", {16'd0, right_acc}, {16'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
    end
    if (fs_next) begin
      tx_word = sr ? val : (pend_v ? pend : tx_word);
      pend_v = 1'b0;
      exp_q.push_back(tx_word);
      if (exp_ur && ur_cnt < 255) ur_cnt++;
    end else if (sr) begin
      pend = val;
      pend_v = 1'b1;
    end
    @(posedge clk);
    n++;
  endtask

  task automatic run_idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0);
  endtask

  // Idle until the start of the given bit slot, bounded to a few frames
  task automatic run_to_bit(input int t);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ((n % (2 * D)) == 0 && ((n / (2 * D)) % 32) == t) break;
      step(1'b0, 16'h0);
    end
  endtask

  initial begin
    apply_reset("por");

    // No samples: every frame underruns and sends zeros
    run_idle(2 * FRAME + 8);

    // One sample between frames is sent in both slots
    run_to_bit(20);
    step(1'b1, 16'hA5C3);
    run_to_bit(1);
    run_idle(FRAME);

    // Two samples before one frame start: the last one wins
    run_to_bit(5);
    step(1'b1, 16'h1234);
    run_idle(10);
    step(1'b1, 16'h8001);
    run_to_bit(1);
    run_idle(FRAME);

    // Sample strobed in the new_frame clk bypasses the holding register
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (fs_at(n + 1)) break;
      step(1'b0, 16'h0);
    end
    step(1'b1, 16'h7FFF);
    run_idle(2 * FRAME);

    // Random sample traffic, including random alignment to frame starts
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 99) == 0) step(1'b1, 16'($urandom));
      else step(1'b0, 16'h0);
    end

    // Reset in the middle of a left slot, then restart like power-up
    run_to_bit(10);
    apply_reset("mid");
    run_idle(FRAME + 10);

`ifdef I2S_UNDERRUN_CNT_EN
    run_idle(300 * FRAME);
    check_eq("ucnt_sat", {24'd0, underrun_count}, 32'd255);
    apply_reset("ucnt_rst");
    run_idle(8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
